// File: rtl/uart_pkg.sv
// Shared UART slave register map and FSM state encoding for the letter
// transmit and receive paths.
package uart_pkg;

    localparam int unsigned RX_BASE     = 0;
    localparam int unsigned TX_BASE     = 4;
    localparam int unsigned STATUS_BASE = 8;
    localparam int unsigned RX_OK_BIT   = 7;
    localparam int unsigned TX_OK_BIT   = 6;

    localparam int unsigned AVM_AW = 5;
    localparam int unsigned AVM_DW = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } uart_state_e;

    typedef struct packed {
        logic [AVM_AW-1:0] address;
        logic [AVM_DW-1:0] writedata;
        logic              read;
        logic              write;
    } avm_cmd_t;

    function automatic logic [AVM_DW-1:0] byte_to_word(input logic [BYTE_W-1:0] b);
        return {(AVM_DW - BYTE_W)'(0), b};
    endfunction

endpackage

// File: rtl/uart_letter_tx_if.sv
// Upstream byte handshake plus Avalon-MM master bus for the letter transmitter.
interface uart_letter_tx_if;
    import uart_pkg::*;

    logic              i_valid;
    logic [BYTE_W-1:0] i_data;
    logic              o_ready;

    logic [AVM_AW-1:0] avm_address;
    logic              avm_read;
    logic [AVM_DW-1:0] avm_readdata;
    logic              avm_write;
    logic [AVM_DW-1:0] avm_writedata;
    logic              avm_waitrequest;

    modport master (
        input  i_valid, i_data, avm_readdata, avm_waitrequest,
        output o_ready, avm_address, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output i_valid, i_data, avm_readdata, avm_waitrequest,
        input  o_ready, avm_address, avm_read, avm_write, avm_writedata
    );

endinterface

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with registered occupancy count; head is read combinationally.
module byte_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    data_in,
    input  logic          pop,
    output logic [7:0]    data_out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_letter_tx.sv
// Drains queued letter bytes into the UART TX register, polling status for TX_OK
// before every write.
module uart_letter_tx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TX_BASE     = uart_pkg::TX_BASE,
    parameter int unsigned STATUS_BASE = uart_pkg::STATUS_BASE,
    parameter int unsigned TX_OK_BIT   = uart_pkg::TX_OK_BIT
) (
    input  logic                      avm_clk,
    input  logic                      avm_rst,
    uart_letter_tx_if.master          bus,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                      o_busy,
    output logic                      o_overflow
);
    import uart_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e       state_q, state_n;
    avm_cmd_t          cmd_q, cmd_n;
    logic              busy_n;
    logic              push;
    logic              pop;
    logic [BYTE_W-1:0] head;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic              fifo_full;
    logic              fifo_empty;

    assign bus.o_ready = !fifo_full;
    assign push        = bus.i_valid && bus.o_ready;
    assign pop         = (state_q == S_WRITE) && !bus.avm_waitrequest;
    assign count_next  = fifo_count + CW'(push) - CW'(pop);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (avm_clk),
        .rst      (avm_rst),
        .push     (push),
        .data_in  (bus.i_data),
        .pop      (pop),
        .data_out (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Next state and next Avalon command; outputs hold while waitrequest is high.
    always_comb begin
        state_n = state_q;
        cmd_n   = cmd_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_n       = S_QUERY;
                    cmd_n.read    = 1'b1;
                    cmd_n.write   = 1'b0;
                    cmd_n.address = AVM_AW'(STATUS_BASE);
                end
            end
            S_QUERY: begin
                if (!bus.avm_waitrequest && bus.avm_readdata[TX_OK_BIT]) begin
                    state_n         = S_WRITE;
                    cmd_n.read      = 1'b0;
                    cmd_n.write     = 1'b1;
                    cmd_n.address   = AVM_AW'(TX_BASE);
                    cmd_n.writedata = byte_to_word(head);
                end
            end
            S_WRITE: begin
                if (!bus.avm_waitrequest) begin
                    cmd_n.write = 1'b0;
                    if (count_next != '0) begin
                        state_n       = S_QUERY;
                        cmd_n.read    = 1'b1;
                        cmd_n.address = AVM_AW'(STATUS_BASE);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n     = S_IDLE;
                cmd_n.read  = 1'b0;
                cmd_n.write = 1'b0;
            end
        endcase
        busy_n = (state_n != S_IDLE) || (count_next != '0);
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state_q <= state_n;
            cmd_q   <= cmd_n;
            o_busy  <= busy_n;
            if (bus.i_valid && !bus.o_ready) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign bus.avm_address   = cmd_q.address;
    assign bus.avm_read      = cmd_q.read;
    assign bus.avm_write     = cmd_q.write;
    assign bus.avm_writedata = cmd_q.writedata;
    assign o_count           = fifo_count;

endmodule

// File: tb/tb_uart_letter_tx.sv
// Scoreboard bench for uart_letter_tx: queued bytes must reach the TX register in order.
module tb_uart_letter_tx;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } obs_t;

    logic          avm_clk = 1'b0;
    logic          avm_rst;
    logic [CW-1:0] o_count;
    logic          o_busy;
    logic          o_overflow;

    uart_letter_tx_if bus ();

    uart_letter_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .avm_clk    (avm_clk),
        .avm_rst    (avm_rst),
        .bus        (bus),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_overflow (o_overflow)
    );

    always #5 avm_clk = ~avm_clk;

    obs_t       obs_q [$];
    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int poll_cnt = 0;
    int poll_base = 0;
    int ok_after = 0;
    int ok_mode  = 0;
    int n_both   = 0;
    int bad_rd_addr = 0;

    // UART status model: 0 = never ready, 1 = always ready, 2 = ready after ok_after polls.
    always_comb begin
        case (ok_mode)
            1:       bus.avm_readdata = 32'h40;
            2:       bus.avm_readdata = ((poll_cnt - poll_base) > ok_after) ? 32'h40 : 32'h0;
            default: bus.avm_readdata = 32'h0;
        endcase
    end

    // Bus monitor, sampled mid-cycle after the bench has driven waitrequest.
    always begin
        @(negedge avm_clk);
        #1;
        if (!avm_rst) begin
            if (bus.avm_read && !bus.avm_waitrequest) begin
                poll_cnt++;
                if (bus.avm_address !== 5'd8) bad_rd_addr++;
            end
            if (bus.avm_write && !bus.avm_waitrequest)
                obs_q.push_back('{bus.avm_address, bus.avm_writedata});
            if (bus.avm_read && bus.avm_write) n_both++;
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit wait_rdy, output bit acc);
        @(negedge avm_clk);
        if (wait_rdy)
            for (int k = 0; k < 200 && !bus.o_ready; k++) @(negedge avm_clk);
        acc = bus.o_ready;
        bus.i_valid = 1'b1;
        bus.i_data  = b;
        @(posedge avm_clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge avm_clk);
            k++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        avm_rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data = 8'h0;
        bus.avm_waitrequest = 1'b0;
        repeat (2) @(negedge avm_clk);
        n_checks++;
        if ({bus.avm_read, bus.avm_write} !== 2'b00) $display("FAIL reset_rw: got %b want 00", {bus.avm_read, bus.avm_write});
        else n_pass++;
        n_checks++;
        if (bus.avm_address !== 5'd0 || bus.avm_writedata !== 32'd0)
            $display("FAIL reset_addr_data: got %0h/%0h want 0/0", bus.avm_address, bus.avm_writedata);
        else n_pass++;
        n_checks++;
        if ({o_overflow, o_busy, bus.o_ready} !== 3'b001) $display("FAIL reset_flags: got %b want 001", {o_overflow, o_busy, bus.o_ready});
        else n_pass++;
        n_checks++;
        if (o_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", o_count);
        else n_pass++;
        avm_rst = 1'b0;
        @(negedge avm_clk);
    endtask

    task automatic test_single();
        bit acc;
        bit ok;
        obs_t o;
        int base;
        ok_mode = 1;
        base = poll_cnt;
        push_byte(8'h41, 1'b1, acc);
        exp_q.push_back(8'h41);
        @(negedge avm_clk);
        n_checks++;
        if (o_count !== 5'd1 || bus.avm_read !== 1'b0) $display("FAIL single_t1: got count=%0d read=%b want 1/0", o_count, bus.avm_read);
        else n_pass++;
        @(negedge avm_clk);
        n_checks++;
        if (bus.avm_read !== 1'b1 || bus.avm_address !== 5'd8) $display("FAIL single_t2_read: got read=%b addr=%0d want 1/8", bus.avm_read, bus.avm_address);
        else n_pass++;
        @(negedge avm_clk);
        n_checks++;
        if (bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0 || bus.avm_address !== 5'd4)
            $display("FAIL single_t3_write: got wr=%b rd=%b addr=%0d want 1/0/4", bus.avm_write, bus.avm_read, bus.avm_address);
        else n_pass++;
        wait_obs(1, 20, ok);
        repeat (3) @(negedge avm_clk);
        n_checks++;
        if (obs_q.size() !== 1) $display("FAIL single_nwrites: got %0d want 1", obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (o.addr !== 5'd4 || o.data !== 32'h0000_0041) $display("FAIL single_data: got addr=%0d data=%h want 4/00000041", o.addr, o.data);
            else n_pass++;
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (poll_cnt - base !== 1) $display("FAIL single_nreads: got %0d want 1", poll_cnt - base);
        else n_pass++;
        n_checks++;
        if (o_count !== 5'd0 || o_busy !== 1'b0) $display("FAIL single_idle: got count=%0d busy=%b want 0/0", o_count, o_busy);
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_polling();
        bit acc;
        bit ok;
        obs_t o;
        ok_mode = 2;
        ok_after = 5;
        poll_base = poll_cnt;
        push_byte(8'h5A, 1'b1, acc);
        for (int k = 0; k < 50 && (poll_cnt - poll_base) < 5; k++) @(negedge avm_clk);
        n_checks++;
        if (obs_q.size() !== 0 || bus.avm_write !== 1'b0) $display("FAIL poll_early_write: got writes=%0d wr=%b want 0/0", obs_q.size(), bus.avm_write);
        else n_pass++;
        wait_obs(1, 50, ok);
        repeat (4) @(negedge avm_clk);
        n_checks++;
        if (poll_cnt - poll_base !== 6) $display("FAIL poll_nreads: got %0d want 6", poll_cnt - poll_base);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 1) $display("FAIL poll_nwrites: got %0d want 1", obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (o.addr !== 5'd4 || o.data !== 32'h0000_005A) $display("FAIL poll_data: got addr=%0d data=%h want 4/0000005a", o.addr, o.data);
            else n_pass++;
        end
        obs_q.delete();
        ok_mode = 1;
    endtask

    task automatic test_stall();
        bit acc;
        bit ok;
        obs_t o;
        logic [38:0] snap;
        ok_mode = 1;
        push_byte(8'hC3, 1'b1, acc);
        for (int k = 0; k < 20 && !bus.avm_read; k++) @(negedge avm_clk);
        n_checks++;
        if (bus.avm_read !== 1'b1) $display("FAIL stall_rd_seen: got %b want 1", bus.avm_read);
        else n_pass++;
        bus.avm_waitrequest = 1'b1;
        snap = {bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write};
        repeat (3) begin
            @(negedge avm_clk);
            n_checks++;
            if ({bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write} !== snap)
                $display("FAIL stall_rd_hold: got %h want %h", {bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write}, snap);
            else n_pass++;
        end
        bus.avm_waitrequest = 1'b0;
        @(negedge avm_clk);
        n_checks++;
        if (bus.avm_write !== 1'b1 || bus.avm_address !== 5'd4 || bus.avm_writedata !== 32'hC3)
            $display("FAIL stall_wr_start: got wr=%b addr=%0d data=%h want 1/4/000000c3", bus.avm_write, bus.avm_address, bus.avm_writedata);
        else n_pass++;
        bus.avm_waitrequest = 1'b1;
        snap = {bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write};
        repeat (3) begin
            @(negedge avm_clk);
            n_checks++;
            if ({bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write} !== snap || o_count !== 5'd1)
                $display("FAIL stall_wr_hold: got %h count=%0d want %h count=1", {bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write}, o_count, snap);
            else n_pass++;
        end
        bus.avm_waitrequest = 1'b0;
        wait_obs(1, 10, ok);
        repeat (5) @(negedge avm_clk);
        n_checks++;
        if (obs_q.size() !== 1 || o_count !== 5'd0) $display("FAIL stall_single_pop: got writes=%0d count=%0d want 1/0", obs_q.size(), o_count);
        else n_pass++;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (o.data !== 32'h0000_00C3) $display("FAIL stall_data: got %h want 000000c3", o.data);
            else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_full();
        bit acc;
        bit ok;
        obs_t o;
        logic [7:0] e;
        ok_mode = 0;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i), 1'b0, acc);
            n_checks++;
            if (acc !== (i < 16)) $display("FAIL full_ready[%0d]: got %b want %b", i, acc, (i < 16));
            else n_pass++;
            if (i < 16) exp_q.push_back(8'(i));
        end
        @(negedge avm_clk);
        n_checks++;
        if ({bus.o_ready, o_overflow} !== 2'b01 || o_count !== 5'd16)
            $display("FAIL full_state: got ready=%b ovf=%b count=%0d want 0/1/16", bus.o_ready, o_overflow, o_count);
        else n_pass++;
        ok_mode = 1;
        wait_obs(16, 300, ok);
        n_checks++;
        if (!ok) $display("FAIL full_drain_timeout: got %0d writes want 16", obs_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.addr !== 5'd4 || o.data !== {24'h0, e}) $display("FAIL full_order: got addr=%0d data=%h want 4/%h", o.addr, o.data, {24'h0, e});
            else n_pass++;
        end
        repeat (10) @(negedge avm_clk);
        n_checks++;
        if (obs_q.size() !== 0 || o_count !== 5'd0 || o_overflow !== 1'b1)
            $display("FAIL full_after: got extra=%0d count=%0d ovf=%b want 0/0/1", obs_q.size(), o_count, o_overflow);
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit ok;
        obs_t o;
        logic [7:0] b;
        logic [7:0] e;
        int n_acc = 0;
        ok_mode = 1;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            push_byte(b, 1'b1, acc);
            if (acc) begin
                exp_q.push_back(b);
                n_acc++;
            end
            if ($urandom_range(3) == 0) @(negedge avm_clk);
        end
        n_checks++;
        if (n_acc !== 40) $display("FAIL stream_accepted: got %0d want 40", n_acc);
        else n_pass++;
        wait_obs(40, 400, ok);
        repeat (4) @(negedge avm_clk);
        n_checks++;
        if (obs_q.size() !== 40) $display("FAIL stream_nwrites: got %0d want 40", obs_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.addr !== 5'd4 || o.data !== {24'h0, e}) $display("FAIL stream_order: got addr=%0d data=%h want 4/%h", o.addr, o.data, {24'h0, e});
            else n_pass++;
        end
        n_checks++;
        if (o_count !== 5'd0 || o_busy !== 1'b0) $display("FAIL stream_idle: got count=%0d busy=%b want 0/0", o_count, o_busy);
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        bit acc;
        bit ok;
        obs_t o;
        ok_mode = 1;
        push_byte(8'h77, 1'b1, acc);
        push_byte(8'h78, 1'b1, acc);
        for (int k = 0; k < 20 && !bus.avm_write; k++) @(negedge avm_clk);
        bus.avm_waitrequest = 1'b1;
        n_checks++;
        if (bus.avm_write !== 1'b1) $display("FAIL rstw_wr_seen: got %b want 1", bus.avm_write);
        else n_pass++;
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.avm_read, bus.avm_write, o_busy, o_overflow, bus.o_ready} !== 5'b00001 ||
            bus.avm_address !== 5'd0 || bus.avm_writedata !== 32'd0 || o_count !== 5'd0)
            $display("FAIL rstw_values: got rd=%b wr=%b busy=%b ovf=%b rdy=%b addr=%0d data=%h count=%0d want all reset",
                     bus.avm_read, bus.avm_write, o_busy, o_overflow, bus.o_ready, bus.avm_address, bus.avm_writedata, o_count);
        else n_pass++;
        @(negedge avm_clk);
        n_checks++;
        if ({bus.avm_read, bus.avm_write} !== 2'b00 || o_count !== 5'd0) $display("FAIL rstw_hold: got rw=%b count=%0d want 00/0", {bus.avm_read, bus.avm_write}, o_count);
        else n_pass++;
        avm_rst = 1'b0;
        bus.avm_waitrequest = 1'b0;
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL rstw_no_write: got %0d want 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
        push_byte(8'h99, 1'b1, acc);
        wait_obs(1, 20, ok);
        repeat (5) @(negedge avm_clk);
        n_checks++;
        if (obs_q.size() !== 1 || o_count !== 5'd0) $display("FAIL rstw_fresh: got writes=%0d count=%0d want 1/0", obs_q.size(), o_count);
        else n_pass++;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (o.addr !== 5'd4 || o.data !== 32'h0000_0099) $display("FAIL rstw_data: got addr=%0d data=%h want 4/00000099", o.addr, o.data);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_polling();
        test_stall();
        test_full();
        test_back_to_back();
        test_reset_mid_write();
        n_checks++;
        if (n_both !== 0) $display("FAIL rd_wr_overlap: got %0d want 0", n_both);
        else n_pass++;
        n_checks++;
        if (bad_rd_addr !== 0) $display("FAIL read_addr: got %0d bad reads want 0", bad_rd_addr);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
